// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bundle between the sequencer and alu_seq.
//   Request side : in_valid, in_ready, op, a, b
//   Response side: out_valid, out_ready, o1, o2, flags {DE,OF,CF,SF,ZF}
//   master = sequencer (issues requests, consumes results)
//   slave  = alu_seq
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] o1;
  logic [WIDTH-1:0] o2;
  logic [4:0]       flags;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, o1, o2, flags
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, o1, o2, flags
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with valid/ready handshakes.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (aborts any pending operation)
//   bus  : alu_seq_if slave port (request a/b/op, result o1/o2/flags)
// Single-cycle ops finish one cycle after accept; MUL/IMUL/DIV/IDIV iterate
// one bit per cycle for WIDTH cycles (sign fix-up folded into the last one).
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int LOG2  = 4
) (
  input logic   clk,
  input logic   rst,
  alu_seq_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3,  OP_XOR = 4'd4,  OP_NEG = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6,  OP_SHR = 4'd7,  OP_SAR = 4'd8;
  localparam logic [3:0] OP_ROL = 4'd9,  OP_ROR = 4'd10, OP_MUL = 4'd11;
  localparam logic [3:0] OP_IMUL = 4'd12, OP_DIV = 4'd13, OP_IDIV = 4'd14;

  localparam logic [WIDTH-1:0]   ZERO    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]   ONES    = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]   MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [2*WIDTH-1:0] ZERO2   = {(2*WIDTH){1'b0}};
  localparam logic [LOG2-1:0]    N_ZERO  = {LOG2{1'b0}};
  localparam logic [LOG2:0]      CNT_INIT = (LOG2+1)'(WIDTH);
  localparam logic [LOG2:0]      CNT_ONE  = (LOG2+1)'(1);
  localparam logic [LOG2:0]      CNT_ZERO = (LOG2+1)'(0);

  // Two's-complement magnitude for signed ops; MIN_NEG maps onto itself,
  // which is the correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic is_signed);
    if (is_signed && v[WIDTH-1]) begin
      return ZERO - v;
    end else begin
      return v;
    end
  endfunction

  logic [1:0]       state_r;
  logic [LOG2:0]    cnt_r;
  logic [3:0]       op_r;
  logic [WIDTH-1:0] hi_r, lo_r, opd_r;
  logic             neg_r, rneg_r;
  logic [WIDTH-1:0] o1_r, o2_r;
  logic [4:0]       flags_r;
  logic             in_ready_r, out_valid_r;

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.o1        = o1_r;
  assign bus.o2        = o2_r;
  assign bus.flags     = flags_r;

  // Single-cycle datapath terms
  logic [LOG2-1:0]     n_s, rot_amt_s;
  logic [WIDTH:0]      add_s, sub_s, shl_s, shr_s;
  logic signed [WIDTH:0] sar_s;
  logic [WIDTH-1:0]    rot_s;
  logic                signed_op_s, iter_op_s;

  assign n_s        = bus.b[LOG2-1:0];
  assign add_s      = {1'b0, bus.a} + {1'b0, bus.b};
  assign sub_s      = {1'b0, bus.a} - {1'b0, bus.b};
  assign shl_s      = {1'b0, bus.a} << n_s;
  assign shr_s      = {bus.a, 1'b0} >> n_s;
  assign sar_s      = $signed({bus.a, 1'b0}) >>> n_s;
  // Rotate-left by n is rotate-right by (-n mod WIDTH); one shifter serves both.
  assign rot_amt_s  = (bus.op == OP_ROL) ? (N_ZERO - n_s) : n_s;
  assign rot_s      = WIDTH'({bus.a, bus.a} >> rot_amt_s);
  assign signed_op_s = (bus.op == OP_IMUL) || (bus.op == OP_IDIV);

  logic [WIDTH-1:0] alu_o1_s, alu_o2_s;
  logic [4:0]       alu_flags_s;
  logic             cf_s, of_s, de_s, keep_s, clr_s, div_err_s;

  // Single-cycle result, flags and divide-error detection at accept time
  always_comb begin
    alu_o1_s  = ZERO;
    alu_o2_s  = ZERO;
    cf_s      = 1'b0;
    of_s      = 1'b0;
    de_s      = 1'b0;
    keep_s    = 1'b0;
    clr_s     = 1'b0;
    div_err_s = 1'b0;
    case (bus.op)
      OP_ADD: begin
        alu_o1_s = add_s[WIDTH-1:0];
        cf_s     = add_s[WIDTH];
        of_s     = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (add_s[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_o1_s = sub_s[WIDTH-1:0];
        cf_s     = sub_s[WIDTH];
        of_s     = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (sub_s[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_AND: alu_o1_s = bus.a & bus.b;
      OP_OR:  alu_o1_s = bus.a | bus.b;
      OP_XOR: alu_o1_s = bus.a ^ bus.b;
      OP_NEG: begin
        alu_o1_s = ZERO - bus.a;
        cf_s     = (bus.a != ZERO);
        of_s     = (bus.a == MIN_NEG);
      end
      OP_SHL: begin
        alu_o1_s = shl_s[WIDTH-1:0];
        cf_s     = shl_s[WIDTH];
        keep_s   = (n_s == N_ZERO);
      end
      OP_SHR: begin
        alu_o1_s = shr_s[WIDTH:1];
        cf_s     = shr_s[0];
        keep_s   = (n_s == N_ZERO);
      end
      OP_SAR: begin
        alu_o1_s = sar_s[WIDTH:1];
        cf_s     = sar_s[0];
        keep_s   = (n_s == N_ZERO);
      end
      OP_ROL: begin
        alu_o1_s = rot_s;
        cf_s     = rot_s[0];
        keep_s   = (n_s == N_ZERO);
      end
      OP_ROR: begin
        alu_o1_s = rot_s;
        cf_s     = rot_s[WIDTH-1];
        keep_s   = (n_s == N_ZERO);
      end
      OP_MUL, OP_IMUL: begin
        alu_o1_s = ZERO;
      end
      OP_DIV: begin
        if (bus.b == ZERO) begin
          div_err_s = 1'b1;
          de_s      = 1'b1;
          alu_o1_s  = ONES;
          alu_o2_s  = bus.a;
        end else begin
          div_err_s = 1'b0;
        end
      end
      OP_IDIV: begin
        if (bus.b == ZERO) begin
          div_err_s = 1'b1;
          de_s      = 1'b1;
          alu_o1_s  = ONES;
          alu_o2_s  = bus.a;
        end else if ((bus.a == MIN_NEG) && (bus.b == ONES)) begin
          div_err_s = 1'b1;
          de_s      = 1'b1;
          alu_o1_s  = bus.a;
          alu_o2_s  = ZERO;
        end else begin
          div_err_s = 1'b0;
        end
      end
      default: clr_s = 1'b1;
    endcase
    // Zero shift amount leaves DE/OF/CF as they were; only ZF/SF follow o1.
    if (clr_s) begin
      alu_flags_s = 5'b00000;
    end else if (keep_s) begin
      alu_flags_s = {flags_r[4:2], alu_o1_s[WIDTH-1], (alu_o1_s == ZERO)};
    end else begin
      alu_flags_s = {de_s, of_s, cf_s, alu_o1_s[WIDTH-1], (alu_o1_s == ZERO)};
    end
  end

  // Iterative step terms: shift-add multiply, restoring divide
  logic [WIDTH:0]     mul_sum_s, rem_sh_s, rem_diff_s;
  logic [WIDTH-1:0]   div_hi_s, div_lo_s;
  logic [2*WIDTH-1:0] prod_s, prod_fix_s;
  logic               is_mul_s;

  assign is_mul_s   = (op_r == OP_MUL) || (op_r == OP_IMUL);
  assign mul_sum_s  = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opd_r} : {(WIDTH+1){1'b0}});
  assign prod_s     = {mul_sum_s, lo_r[WIDTH-1:1]};
  assign prod_fix_s = neg_r ? (ZERO2 - prod_s) : prod_s;
  assign rem_sh_s   = {hi_r, lo_r[WIDTH-1]};
  assign rem_diff_s = rem_sh_s - {1'b0, opd_r};

  // Restoring step: keep the trial difference only when it did not borrow
  always_comb begin
    div_hi_s = rem_sh_s[WIDTH-1:0];
    div_lo_s = {lo_r[WIDTH-2:0], 1'b0};
    if (!rem_diff_s[WIDTH]) begin
      div_hi_s = rem_diff_s[WIDTH-1:0];
      div_lo_s = {lo_r[WIDTH-2:0], 1'b1};
    end else begin
      div_hi_s = rem_sh_s[WIDTH-1:0];
    end
  end

  logic [WIDTH-1:0] fin_o1_s, fin_o2_s;
  logic             fin_cf_s;

  // Final-cycle result with sign correction for the signed variants
  always_comb begin
    fin_o1_s = ZERO;
    fin_o2_s = ZERO;
    fin_cf_s = 1'b0;
    case (op_r)
      OP_MUL: begin
        fin_o1_s = prod_s[WIDTH-1:0];
        fin_o2_s = prod_s[2*WIDTH-1:WIDTH];
        fin_cf_s = (fin_o2_s != ZERO);
      end
      OP_IMUL: begin
        fin_o1_s = prod_fix_s[WIDTH-1:0];
        fin_o2_s = prod_fix_s[2*WIDTH-1:WIDTH];
        fin_cf_s = (fin_o2_s != {WIDTH{fin_o1_s[WIDTH-1]}});
      end
      OP_DIV: begin
        fin_o1_s = div_lo_s;
        fin_o2_s = div_hi_s;
      end
      OP_IDIV: begin
        fin_o1_s = neg_r  ? (ZERO - div_lo_s) : div_lo_s;
        fin_o2_s = rneg_r ? (ZERO - div_hi_s) : div_hi_s;
      end
      default: fin_o1_s = ZERO;
    endcase
  end

  // Control FSM, iteration registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= CNT_ZERO;
      op_r        <= 4'd0;
      hi_r        <= ZERO;
      lo_r        <= ZERO;
      opd_r       <= ZERO;
      neg_r       <= 1'b0;
      rneg_r      <= 1'b0;
      o1_r        <= ZERO;
      o2_r        <= ZERO;
      flags_r     <= 5'b00000;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            op_r       <= bus.op;
            in_ready_r <= 1'b0;
            iter_op_s_dummy_guard: begin end
            if ((bus.op == OP_MUL) || (bus.op == OP_IMUL) ||
                (((bus.op == OP_DIV) || (bus.op == OP_IDIV)) && !div_err_s)) begin
              hi_r    <= ZERO;
              lo_r    <= magnitude(bus.a, signed_op_s);
              opd_r   <= magnitude(bus.b, signed_op_s);
              neg_r   <= signed_op_s && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
              rneg_r  <= signed_op_s && bus.a[WIDTH-1];
              cnt_r   <= CNT_INIT;
              state_r <= BUSY;
            end else begin
              o1_r        <= alu_o1_s;
              o2_r        <= alu_o2_s;
              flags_r     <= alu_flags_s;
              out_valid_r <= 1'b1;
              state_r     <= DONE;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          hi_r  <= is_mul_s ? mul_sum_s[WIDTH:1] : div_hi_s;
          lo_r  <= is_mul_s ? {mul_sum_s[0], lo_r[WIDTH-1:1]} : div_lo_s;
          cnt_r <= (cnt_r != CNT_ZERO) ? (cnt_r - CNT_ONE) : cnt_r;
          if (cnt_r == CNT_ONE) begin
            o1_r        <= fin_o1_s;
            o2_r        <= fin_o2_s;
            flags_r     <= {1'b0, fin_cf_s, fin_cf_s, fin_o1_s[WIDTH-1], (fin_o1_s == ZERO)};
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            state_r <= BUSY;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign iter_op_s = 1'b0;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq (WIDTH=16). Directed vectors
// followed by randomized operations compared against an arithmetic model.
module tb_alu_seq;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [4:0]  model_flags = 5'b00000;
  logic [15:0] last_o1, last_o2;
  logic [4:0]  last_flags;

  alu_seq_if #(.WIDTH(16)) bus ();
  alu_seq #(.WIDTH(16), .LOG2(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference behaviour expressed with plain integer arithmetic
  function automatic void model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                input logic [4:0] pf, output logic [15:0] o1,
                                output logic [15:0] o2, output logic [4:0] fl, output int lat);
    int ua, ub, sa, sb, n;
    longint p;
    logic cf, of, de, keep;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b); n = b[3:0];
    o1 = 16'h0; o2 = 16'h0; cf = 1'b0; of = 1'b0; de = 1'b0; keep = 1'b0; lat = 1;
    case (op)
      4'd0: begin o1 = 16'(ua + ub); cf = (ua + ub) > 65535; of = (sa + sb > 32767) || (sa + sb < -32768); end
      4'd1: begin o1 = 16'(ua - ub); cf = ua < ub; of = (sa - sb > 32767) || (sa - sb < -32768); end
      4'd2: o1 = a & b;
      4'd3: o1 = a | b;
      4'd4: o1 = a ^ b;
      4'd5: begin o1 = 16'(-ua); cf = ua != 0; of = ua == 32768; end
      4'd6: begin o1 = 16'(ua << n); cf = (n != 0) && (((ua >> (16 - n)) & 1) != 0); keep = n == 0; end
      4'd7: begin o1 = 16'(ua >> n); cf = (n != 0) && (((ua >> (n - 1)) & 1) != 0); keep = n == 0; end
      4'd8: begin o1 = 16'(sa >>> n); cf = (n != 0) && (((ua >> (n - 1)) & 1) != 0); keep = n == 0; end
      4'd9: begin o1 = 16'((ua << n) | (ua >> (16 - n))); cf = o1[0]; keep = n == 0; end
      4'd10: begin o1 = 16'((ua >> n) | (ua << (16 - n))); cf = o1[15]; keep = n == 0; end
      4'd11: begin p = longint'(ua) * longint'(ub); o1 = p[15:0]; o2 = p[31:16]; cf = p > 65535; of = cf; lat = 17; end
      4'd12: begin p = longint'(sa) * longint'(sb); o1 = p[15:0]; o2 = p[31:16]; cf = (p > 32767) || (p < -32768); of = cf; lat = 17; end
      4'd13: begin
        if (ub == 0) begin de = 1'b1; o1 = 16'hFFFF; o2 = a; end
        else begin o1 = 16'(ua / ub); o2 = 16'(ua % ub); lat = 17; end
      end
      4'd14: begin
        if (ub == 0) begin de = 1'b1; o1 = 16'hFFFF; o2 = a; end
        else if (sa == -32768 && sb == -1) begin de = 1'b1; o1 = a; o2 = 16'h0; end
        else begin o1 = 16'(sa / sb); o2 = 16'(sa % sb); lat = 17; end
      end
      default: begin o1 = 16'h0; end
    endcase
    if (op == 4'd15) fl = 5'b00000;
    else if (keep) fl = {pf[4:2], o1[15], o1 == 16'h0};
    else fl = {de, of, cf, o1[15], o1 == 16'h0};
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input int hold);
    logic [15:0] e1, e2;
    logic [4:0]  ef;
    int elat, lat, w;
    model(op, a, b, model_flags, e1, e2, ef, elat);
    @(negedge clk);
    w = 0;
    while (!bus.in_ready && w < 50) begin @(negedge clk); w++; end
    if (!bus.in_ready) check("in_ready_wait", bus.in_ready, 1'b1);
    bus.in_valid = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      check("busy_in_ready", bus.in_ready, 1'b0);
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("latency op%0d", op), lat, elat);
    check($sformatf("o1 op%0d a=%h b=%h", op, a, b), bus.o1, e1);
    check($sformatf("o2 op%0d a=%h b=%h", op, a, b), bus.o2, e2);
    check($sformatf("flags op%0d a=%h b=%h", op, a, b), bus.flags, ef);
    last_o1 = bus.o1; last_o2 = bus.o2; last_flags = bus.flags;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_valid", bus.out_valid, 1'b1);
      check("hold_in_ready", bus.in_ready, 1'b0);
      check("hold_stable", {bus.o1, bus.o2, bus.flags}, {last_o1, last_o2, last_flags});
    end
    @(negedge clk); bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("release_valid", bus.out_valid, 1'b0);
    check("release_in_ready", bus.in_ready, 1'b1);
    model_flags = ef;
  endtask

  task automatic expect_last(input string tag, input logic [15:0] o1, input logic [15:0] o2, input logic [4:0] fl);
    check({tag, "_o1"}, last_o1, o1);
    check({tag, "_o2"}, last_o2, o2);
    check({tag, "_flags"}, last_flags, fl);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, bus.out_valid, 1'b0);
    check({tag, "_in_ready"}, bus.in_ready, 1'b1);
    check({tag, "_outputs"}, {bus.o1, bus.o2, bus.flags}, 37'h0);
  endtask

  initial begin
    logic [3:0]  rop;
    logic [15:0] ra, rb;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.op = 4'd0; bus.a = 16'h0; bus.b = 16'h0;
    repeat (3) @(posedge clk);
    #1 check_reset_state("reset");
    rst = 1'b0;

    run_op(4'd0, 16'h7FFF, 16'h0001, 0);  expect_last("add", 16'h8000, 16'h0000, 5'b01010);
    run_op(4'd1, 16'h0000, 16'h0001, 0);  expect_last("sub", 16'hFFFF, 16'h0000, 5'b00110);
    run_op(4'd11, 16'hFFFF, 16'hFFFF, 0); expect_last("mul", 16'h0001, 16'hFFFE, 5'b01100);
    run_op(4'd12, 16'hFFFF, 16'h0003, 0); expect_last("imul", 16'hFFFD, 16'hFFFF, 5'b00010);
    run_op(4'd13, 16'h0064, 16'h0007, 0); expect_last("div", 16'h000E, 16'h0002, 5'b00000);
    run_op(4'd14, 16'hFF9C, 16'h0007, 0); expect_last("idiv", 16'hFFF2, 16'hFFFE, 5'b00010);
    run_op(4'd13, 16'h1234, 16'h0000, 0); expect_last("div0", 16'hFFFF, 16'h1234, 5'b10010);
    run_op(4'd14, 16'h8000, 16'hFFFF, 0); expect_last("idivov", 16'h8000, 16'h0000, 5'b10010);
    run_op(4'd4, 16'h00F0, 16'h0FF0, 5);  expect_last("bp_xor", 16'h0F00, 16'h0000, 5'b00000);
    run_op(4'd15, 16'h1234, 16'h5678, 0); expect_last("rsvd", 16'h0000, 16'h0000, 5'b00000);

    // Reset during the 8th BUSY cycle of a multiply
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = 4'd11; bus.a = 16'h1234; bus.b = 16'h5678;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    check("mid_mul_valid", bus.out_valid, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_state("abort");
    rst = 1'b0;
    model_flags = 5'b00000;
    run_op(4'd7, 16'h0005, 16'h0001, 0);  expect_last("shr", 16'h0002, 16'h0000, 5'b00100);
    run_op(4'd6, 16'h0000, 16'h0000, 0);  expect_last("shl0", 16'h0000, 16'h0000, 5'b00101);

    for (int i = 0; i < 150; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      if ($urandom_range(0, 7) == 0) rb = 16'h0000;
      if ($urandom_range(0, 15) == 0) begin ra = 16'h8000; rb = 16'hFFFF; end
      run_op(rop, ra, rb, $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, clocked successor to the combinational/enable-strobed ALU.
- Operand width is generic. Multiply and divide are iterative (one bit per cycle) rather than single-step.
- Valid/ready handshakes on the input and output sides, plus a registered flag word.
- Sits between the register-file read stage and writeback; the sequencer stalls on in_ready/out_valid.

Parameters:
- WIDTH, 16, operand/result width in bits (≥4, power of two).
- LOG2, 4, log2(WIDTH); shift-amount bits taken from b.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request.
- op  in  4  operation code (see Behaviour).
- a  in  WIDTH  operand A / dividend.
- b  in  WIDTH  operand B / divisor / shift amount.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- o1  out  WIDTH  low result / quotient.
- o2  out  WIDTH  high product / remainder (0 for single-width ops).
- flags  out  5  {DE,OF,CF,SF,ZF}, bit0=ZF.

Behaviour:
- Op codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NEG
  - 6 SHL, 7 SHR, 8 SAR, 9 ROL, 10 ROR
  - 11 MUL, 12 IMUL, 13 DIV, 14 IDIV
  - 15 reserved: result 0, flags 0.
- States: IDLE, BUSY, DONE.
  - in_ready=1 only in IDLE.
  - out_valid=1 only in DONE.
- Accept: when in_valid&&in_ready, latch op/a/b.
  - Ops 0-10, DIV/IDIV error cases, and op 15: IDLE→DONE, result visible the next cycle (latency 1).
  - Ops 11-14: IDLE→BUSY, WIDTH iterations, then →DONE. Latency is WIDTH+1 cycles from accept to out_valid.
- DONE→IDLE when out_ready=1. o1/o2/flags hold stable while out_valid=1 && out_ready=0. No new accept occurs in the DONE cycle.
- Reset: state IDLE, o1=0, o2=0, flags=0, out_valid=0, in_ready=1 the cycle after rst.
  - rst in BUSY or DONE aborts; the pending result is discarded.
  - rst dominates in_valid in the same cycle.
- Flags, written only on the transition into DONE. ZF=(o1==0), SF=o1[WIDTH-1].
  - ADD: CF=carry out of WIDTH bits; OF=signed overflow.
  - SUB: CF=borrow (a<b unsigned); OF=signed overflow.
  - AND/OR/XOR: CF=OF=0.
  - NEG: o1=-a; CF=(a!=0); OF=(a==100..0).
  - Shifts/rotates, amount n=b[LOG2-1:0]:
    - n==0: o1=a, all flags unchanged except ZF/SF.
    - SHL: CF=last bit shifted out (a[WIDTH-n]).
    - SHR/SAR: CF=a[n-1]. SAR sign-fills.
    - ROL: CF=o1[0]. ROR: CF=o1[WIDTH-1].
    - OF=0 for all shifts/rotates.
  - MUL/IMUL: {o2,o1}=full 2·WIDTH product, unsigned/signed. Shift-add, one multiplier bit per cycle. IMUL uses magnitudes, with sign correction in the final cycle.
    - MUL: CF=OF=(o2!=0).
    - IMUL: CF=OF=(o2 != sign-extension of o1).
  - DIV: o1=a/b, o2=a%b. Restoring, one quotient bit per cycle.
  - IDIV: truncates toward zero; remainder takes the sign of a.
  - CF=OF=0 for DIV/IDIV.
  - DE=0 except for divide errors.
- Divide errors (decided at accept, latency 1):
  - b==0: DE=1, o1=all-ones, o2=a.
  - IDIV with a=100..0 and b=all-ones: DE=1, o1=a, o2=0.
- The iteration counter is LOG2+1 bits, counts WIDTH down to 0, and does not wrap.

Test Plan:
- Reset then ADD, WIDTH=16: a=7FFF, b=0001 → o1=8000, flags OF=1 SF=1 CF=0 ZF=0, out_valid one cycle after accept. SUB a=0000, b=0001 → o1=FFFF, CF=1 SF=1 OF=0.
- MUL a=FFFF, b=FFFF → {o2,o1}=FFFE_0001, CF=OF=1, out_valid exactly 17 cycles after accept. in_ready=0 throughout BUSY. IMUL a=FFFF(-1), b=0003 → o2=FFFF, o1=FFFD, CF=OF=0.
- DIV a=0064, b=0007 → o1=000E, o2=0002. IDIV a=FF9C(-100), b=0007 → o1=FFF2, o2=FFFE.
- DIV a=1234, b=0 → DE=1, o1=FFFF, o2=1234, latency 1. IDIV a=8000, b=FFFF → DE=1, o1=8000, o2=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises → o1/o2/flags stable, in_ready=0. Raise out_ready → IDLE the next cycle; a back-to-back request is then accepted.
- Assert rst mid-MUL (cycle 8 of BUSY) → next cycle out_valid=0, in_ready=1, o1=o2=0, flags=0. A following SHR a=0005, b=0001 → o1=0002, CF=1.
